// File: rtl/t03_sprite_loader_if.sv
// Pixel stream channel between the asset source and the sprite loader.
//   pix_valid : source -> loader, pix_data holds a valid pixel
//   pix_data  : source -> loader, pixel value in raster order (row 0 col 0 first)
//   pix_ready : loader -> source, loader accepts a pixel this cycle
// A pixel transfers on a clock edge where pix_valid & pix_ready.
interface t03_sprite_loader_if #(
  parameter int unsigned PIX_W = 8
);
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;

  modport master (output pix_valid, output pix_data, input pix_ready);
  modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/t03_sprite_loader.sv
// Player sprite loader: collects a raster-ordered pixel stream into a shadow
// buffer and copies the complete buffer into the active bitmap on a vblank
// pulse, so the display never sees a half-written sprite.
//   clk        : system clock, all logic on posedge
//   rst        : asynchronous reset, active-low
//   load_start : 1-cycle request to begin a new sprite load
//   load_abort : discard the in-progress or pending load
//   vblank     : 1-cycle pulse at the start of vertical blank
//   pix        : pixel stream channel (slave side)
//   player     : active sprite bitmap, first pixel in the top byte
//   busy       : high while loading or waiting for vblank
//   load_done  : 1-cycle pulse, new bitmap visible on player
//   load_count : pixels accepted so far in the current load
module t03_sprite_loader #(
  parameter int unsigned X_LEN = 15,
  parameter int unsigned Y_LEN = 20,
  parameter int unsigned PIX_W = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_start,
  input  logic                           load_abort,
  input  logic                           vblank,
  t03_sprite_loader_if.slave             pix,
  output logic [X_LEN*Y_LEN*PIX_W-1:0]   player,
  output logic                           busy,
  output logic                           load_done,
  output logic [8:0]                     load_count
);

  localparam int unsigned NPIX = X_LEN * Y_LEN;
  localparam int unsigned W    = NPIX * PIX_W;

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  shadow;
  logic          accept;
  logic          last_accept;
  logic          swap;
  logic          abort_hit;

  // pix_ready already excludes load_abort, so an abort cycle never accepts.
  assign accept      = pix.pix_valid & pix.pix_ready;
  assign last_accept = accept & (load_count == 9'(NPIX - 1));
  assign abort_hit   = load_abort & (state != IDLE);
  assign swap        = (state == PEND) & vblank & ~load_abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load_start && !load_abort) state_nxt = LOAD;
      LOAD: begin
        if (load_abort)       state_nxt = IDLE;
        else if (last_accept) state_nxt = PEND;
      end
      PEND: if (load_abort || vblank) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pix.pix_ready = (state == LOAD) & ~load_abort;
    busy          = (state == LOAD) | (state == PEND);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow     <= '0;
      player     <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
    end else begin
      load_done <= swap;
      if (accept) shadow <= {shadow[W-PIX_W-1:0], pix.pix_data};
      if (swap) player <= shadow;
      if (abort_hit || swap)
        load_count <= '0;
      else if (accept)
        load_count <= load_count + 9'd1;
      else if (state == IDLE && load_start)
        load_count <= '0;
    end
  end

endmodule

// File: tb/tb_t03_sprite_loader.sv
module tb_t03_sprite_loader;

  localparam int NPIX = 300;
  localparam int W    = NPIX * 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_start, load_abort, vblank;
  logic [W-1:0] player;
  logic         busy, load_done;
  logic [8:0]   load_count;

  t03_sprite_loader_if #(.PIX_W(8)) pif ();

  t03_sprite_loader #(.X_LEN(15), .Y_LEN(20), .PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_abort (load_abort),
    .vblank     (vblank),
    .pix        (pif),
    .player     (player),
    .busy       (busy),
    .load_done  (load_done),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic chk_bitmap(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    int bad = -1;
    for (int i = 0; i < NPIX; i++)
      if (bad < 0 && act[W-1-8*i -: 8] !== exp[W-1-8*i -: 8]) bad = i;
    checks++;
    if (bad < 0) passes++;
    else $display("FAIL %s: pixel %0d got %02h want %02h", name, bad,
                  act[W-1-8*bad -: 8], exp[W-1-8*bad -: 8]);
  endtask

  function automatic logic [W-1:0] ramp_map();
    logic [W-1:0] m = '0;
    for (int i = 0; i < NPIX; i++) m[W-1-8*i -: 8] = 8'(i);
    return m;
  endfunction

  function automatic logic [W-1:0] fill_map(input logic [7:0] v);
    logic [W-1:0] m;
    for (int i = 0; i < NPIX; i++) m[W-1-8*i -: 8] = v;
    return m;
  endfunction

  // Scoreboard monitor: every load_done pulse must match the next expected bitmap.
  initial forever begin
    logic [W-1:0] e;
    @(negedge clk);
    if (rst && load_done) begin
      if (exp_q.size() == 0) chk("unexpected_load_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk_bitmap("swap_bitmap", player, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // mode 0: pixel value = index within this call offset by base; mode 1: constant val
  task automatic stream(input int n, input bit mode, input logic [7:0] val,
                        input int base, input bit gaps);
    int sent = 0;
    int budget = 0;
    while (sent < n && budget < 5000) begin
      budget++;
      pif.pix_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pif.pix_data  = mode ? val : 8'(base + sent);
      @(negedge clk);
      if (pif.pix_valid && pif.pix_ready) sent++;
      tick();
    end
    pif.pix_valid = 1'b0;
    if (sent < n) chk("stream_timeout", sent, n);
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ramp;
    ramp = ramp_map();

    // 1. reset with arbitrary inputs active
    rst = 1'b0;
    load_start = 1'b1; load_abort = 1'b0; vblank = 1'b1;
    pif.pix_valid = 1'b1; pif.pix_data = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bitmap("reset_player", player, '0);
    chk("reset_pix_ready", int'(pif.pix_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_load_done", int'(load_done), 0);
    chk("reset_load_count", int'(load_count), 0);
    load_start = 1'b0; vblank = 1'b0; pif.pix_valid = 1'b0;
    #2 rst = 1'b1;
    tick();

    // 2. full ramp load
    start_load();
    @(negedge clk);
    chk("start_busy", int'(busy), 1);
    chk("start_count", int'(load_count), 0);
    tick();
    stream(NPIX, 1'b0, 8'h00, 0, 1'b0);
    @(negedge clk);
    chk("full_count", int'(load_count), NPIX);
    chk("full_busy", int'(busy), 1);
    chk("full_pend_ready", int'(pif.pix_ready), 0);
    chk_bitmap("full_player_before_vblank", player, '0);
    tick();
    exp_q.push_back(ramp);
    pulse_vblank();
    @(negedge clk);
    chk("full_load_done", int'(load_done), 1);
    chk("full_byte_first", int'(player[2399:2392]), 0);
    chk("full_byte_second", int'(player[2391:2384]), 1);
    chk("full_byte_last", int'(player[7:0]), 43);
    tick();
    @(negedge clk);
    chk("full_done_one_cycle", int'(load_done), 0);
    chk("full_idle_busy", int'(busy), 0);
    chk("full_idle_count", int'(load_count), 0);
    tick();

    // 3. gaps, constant A5, extra valid in PEND must not be accepted
    start_load();
    stream(NPIX, 1'b1, 8'hA5, 0, 1'b1);
    pif.pix_valid = 1'b1; pif.pix_data = 8'h11;
    repeat (4) begin
      @(negedge clk);
      chk("pend_ready_low", int'(pif.pix_ready), 0);
      tick();
    end
    pif.pix_valid = 1'b0;
    chk("gap_count", int'(load_count), NPIX);
    exp_q.push_back(fill_map(8'hA5));
    pulse_vblank();
    @(negedge clk);
    chk("gap_load_done", int'(load_done), 1);
    tick();

    // 4. abort mid-load
    start_load();
    stream(150, 1'b1, 8'hFF, 0, 1'b0);
    @(negedge clk);
    chk("abort_pre_count", int'(load_count), 150);
    tick();
    load_abort = 1'b1;
    pif.pix_valid = 1'b1; pif.pix_data = 8'hFF;
    @(negedge clk);
    chk("abort_ready_low", int'(pif.pix_ready), 0);
    tick();
    load_abort = 1'b0; pif.pix_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(load_count), 0);
    chk_bitmap("abort_player_kept", player, fill_map(8'hA5));
    tick();
    pulse_vblank();
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_done", int'(load_done), 0);
      tick();
    end

    // 5. load_start mid-load, vblank on the final accept
    start_load();
    stream(100, 1'b1, 8'h3C, 0, 1'b0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    @(negedge clk);
    chk("midstart_count", int'(load_count), 100);
    chk("midstart_busy", int'(busy), 1);
    tick();
    stream(199, 1'b1, 8'h3C, 0, 1'b0);
    pif.pix_valid = 1'b1; pif.pix_data = 8'h3C; vblank = 1'b1;
    tick();
    pif.pix_valid = 1'b0; vblank = 1'b0;
    @(negedge clk);
    chk("coinc_no_done", int'(load_done), 0);
    chk("coinc_busy", int'(busy), 1);
    chk("coinc_count", int'(load_count), NPIX);
    chk_bitmap("coinc_player_kept", player, fill_map(8'hA5));
    tick();
    exp_q.push_back(fill_map(8'h3C));
    pulse_vblank();
    @(negedge clk);
    chk("coinc_second_done", int'(load_done), 1);
    tick();

    // 6. reset mid-load, then a fresh load
    start_load();
    stream(77, 1'b0, 8'h00, 0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_bitmap("midreset_player", player, '0);
    chk("midreset_busy", int'(busy), 0);
    chk("midreset_count", int'(load_count), 0);
    chk("midreset_ready", int'(pif.pix_ready), 0);
    @(negedge clk);
    #1 rst = 1'b1;
    tick();
    start_load();
    stream(NPIX, 1'b0, 8'h00, 0, 1'b1);
    exp_q.push_back(ramp);
    pulse_vblank();
    @(negedge clk);
    chk("fresh_load_done", int'(load_done), 1);
    tick();
    repeat (2) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 want 0");
    $fatal(1);
  end

endmodule
